// File: rtl/spi_pkg.sv
// spi_pkg: shared state, mode and timing definitions for the SPI master
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, HOLD, DONE} spi_state_t;
  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;
  localparam int MIN_HALF = 2;
endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: half-period timer emitting one tick per SCK edge plus the edge index
module spi_sck_gen #(
  parameter int DIV_WIDTH = 8,
  parameter int EDGE_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DIV_WIDTH:0]    half,
  output logic                  tick,
  output logic [EDGE_WIDTH-1:0] edge_n,
  output logic                  leading
);
  logic [DIV_WIDTH:0] cnt;
  logic [EDGE_WIDTH-1:0] ticks;
  assign tick = en && cnt == half - 1'b1;
  assign edge_n = ticks + 1'b1;
  assign leading = edge_n[0];
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= '0;
      ticks <= '0;
    end else if (tick) begin
      cnt <= '0;
      ticks <= ticks + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_master_mode.sv
// spi_master_mode: CPOL/CPHA-configurable SPI master with run-time length, divider and bit order
module spi_master_mode
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CS = 4,
  parameter int DIV_WIDTH = 8,
  localparam int CW = NUM_CS > 1 ? $clog2(NUM_CS) : 1,
  localparam int LW = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [CW-1:0]         cs_sel,
  input  logic [LW-1:0]         len,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  output logic [NUM_CS-1:0]     spi_cs_n,
  input  logic                  spi_miso
);
  localparam int HW = DIV_WIDTH + 1;
  localparam int EW = $clog2(2 * DATA_WIDTH + 2);
  localparam logic [LW-1:0] DW_L = LW'(DATA_WIDTH);
  spi_state_t state;
  spi_mode_t mode_q;
  logic bad_q, cs_ok, en, tick, leading, sample, shift, last;
  logic [LW-1:0] len_q, len_eff;
  logic [HW-1:0] half_q, half_eff;
  logic [DATA_WIDTH-1:0] sh, sh0, rx;
  logic [EW-1:0] edge_n;
  function automatic logic head(input logic [DATA_WIDTH-1:0] s, input logic l);
    return l ? s[0] : s[DATA_WIDTH-1];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] adv(input logic [DATA_WIDTH-1:0] s, input logic l);
    return l ? s >> 1 : s << 1;
  endfunction
  assign len_eff = (len == '0 || len > DW_L) ? DW_L : len;
  assign half_eff = clk_div == '0 ? HW'(MIN_HALF) : HW'(clk_div) + 1'b1;
  assign cs_ok = int'(cs_sel) < NUM_CS;
  // MSB-first words are left-aligned so the active MSB sits at the top of the shifter
  assign sh0 = lsb_first ? data_in : data_in << (DW_L - len_eff);
  assign en = !bad_q && (state == SETUP || state == TRANSFER || state == HOLD);
  assign last = edge_n == EW'({len_q, 1'b0});
  assign sample = leading ^ mode_q.cpha;
  assign shift = mode_q.cpha ? leading : !leading && !last;
  spi_sck_gen #(.DIV_WIDTH(DIV_WIDTH), .EDGE_WIDTH(EW)) u_sck (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .half(half_q),
    .tick(tick),
    .edge_n(edge_n),
    .leading(leading)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      mode_q <= '0;
      bad_q <= 1'b0;
      len_q <= DW_L;
      half_q <= HW'(MIN_HALF);
      sh <= '0;
      rx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      data_out <= '0;
      spi_sck <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= '1;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          spi_sck <= cpol;
          spi_mosi <= 1'b0;
          spi_cs_n <= '1;
          if (start) begin
            state <= SETUP;
            busy <= 1'b1;
            mode_q <= {cpol, cpha, lsb_first};
            bad_q <= !cs_ok;
            len_q <= len_eff;
            half_q <= half_eff;
            rx <= '0;
            sh <= cpha ? sh0 : adv(sh0, lsb_first);
            spi_mosi <= cs_ok && !cpha && head(sh0, lsb_first);
            spi_cs_n <= cs_ok ? ~(NUM_CS'(1) << cs_sel) : '1;
          end
        end
        SETUP, TRANSFER: begin
          if (bad_q) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            err <= 1'b1;
          end else if (tick) begin
            spi_sck <= ~spi_sck;
            state <= last ? HOLD : TRANSFER;
            if (sample)
              rx <= mode_q.lsb_first ? {spi_miso, rx[DATA_WIDTH-1:1]} : {rx[DATA_WIDTH-2:0], spi_miso};
            if (shift) begin
              spi_mosi <= head(sh, mode_q.lsb_first);
              sh <= adv(sh, mode_q.lsb_first);
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            spi_cs_n <= '1;
            spi_mosi <= 1'b0;
            spi_sck <= mode_q.cpol;
            data_out <= mode_q.lsb_first ? rx >> (DW_L - len_q) : rx;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_mode.sv
// tb_spi_master_mode: randomized self-checking bench with a cycle-timeline reference model
module tb_spi_master_mode;
  localparam int DW = 16;
  localparam int NCS = 5;
  localparam int DIVW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpol = 1'b0;
  logic cpha = 1'b0;
  logic lsb_first = 1'b0;
  logic [2:0] cs_sel = '0;
  logic [4:0] len = '0;
  logic [7:0] clk_div = '0;
  logic [15:0] data_in = '0;
  logic busy, done, err;
  logic [15:0] data_out;
  logic spi_sck, spi_mosi;
  logic spi_miso = 1'b0;
  logic [4:0] spi_cs_n;
  int n_run = 0;
  int n_fail = 0;
  logic [15:0] exp_dout = '0;

  spi_master_mode #(.DATA_WIDTH(DW), .NUM_CS(NCS), .DIV_WIDTH(DIVW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .cs_sel(cs_sel), .len(len), .clk_div(clk_div),
    .data_in(data_in), .busy(busy), .done(done), .err(err), .data_out(data_out),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  task automatic scramble();
    cpol = 1'($urandom);
    cpha = 1'($urandom);
    lsb_first = 1'($urandom);
    cs_sel = 3'($urandom);
    len = 5'($urandom);
    clk_div = 8'($urandom);
    data_in = 16'($urandom);
  endtask

  // Timeline model: start accepted at cycle 0, SCK edge k at 1+k*H, done at 1+(2L+1)*H
  task automatic run_xfer(input logic m_cpol, input logic m_cpha, input logic m_lsb,
                          input logic [2:0] m_cs, input logic [4:0] m_len, input logic [7:0] m_div,
                          input logic [15:0] m_din, input logic [15:0] m_sw,
                          input bit hold_start, input int rst_at);
    int L, H, D, k;
    bit bad, chk_mosi;
    logic tx_bits[16];
    logic sw_bits[16];
    logic [15:0] word;
    logic [4:0] exp_cs;
    logic exp_sck, exp_mosi;
    L = (m_len == 0 || int'(m_len) > 16) ? 16 : int'(m_len);
    H = (m_div == 0) ? 2 : int'(m_div) + 1;
    bad = m_cs >= 3'd5;
    D = bad ? 2 : 1 + (2 * L + 1) * H;
    word = '0;
    for (int i = 0; i < L; i++) begin
      tx_bits[i] = m_lsb ? m_din[i] : m_din[L-1-i];
      sw_bits[i] = m_lsb ? m_sw[i] : m_sw[L-1-i];
      word[i] = m_sw[i];
    end
    cpol = m_cpol;
    cpha = m_cpha;
    lsb_first = m_lsb;
    cs_sel = m_cs;
    len = m_len;
    clk_div = m_div;
    data_in = m_din;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    for (int c = 1; c <= D; c++) begin
      if (c == rst_at) begin
        rst_n = 1'b0;
        cpol = 1'b1;
        @(posedge clk);
        #1;
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy got %b exp 0", busy); end
        n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid done got %b exp 0", done); end
        n_run++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_mid err got %b exp 0", err); end
        n_run++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL rst_mid data_out got %h exp 0000", data_out); end
        n_run++; if (spi_sck !== 1'b0) begin n_fail++; $display("FAIL rst_mid sck got %b exp 0", spi_sck); end
        n_run++; if (spi_mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mid mosi got %b exp 0", spi_mosi); end
        n_run++; if (spi_cs_n !== 5'h1f) begin n_fail++; $display("FAIL rst_mid cs_n got %h exp 1f", spi_cs_n); end
        rst_n = 1'b1;
        start = 1'b0;
        exp_dout = '0;
        return;
      end
      k = (bad || c < 1 + H) ? 0 : (((c - 1) / H > 2 * L) ? 2 * L : (c - 1) / H);
      exp_sck = m_cpol ^ k[0];
      exp_cs = (bad || c == D) ? 5'h1f : ~(5'd1 << m_cs);
      n_run++; if (busy !== (c < D)) begin n_fail++; $display("FAIL busy c=%0d got %b exp %b", c, busy, c < D); end
      n_run++; if (done !== (c == D)) begin n_fail++; $display("FAIL done c=%0d got %b exp %b", c, done, c == D); end
      n_run++; if (err !== (bad && c == D)) begin n_fail++; $display("FAIL err c=%0d got %b exp %b", c, err, bad && c == D); end
      n_run++; if (spi_sck !== exp_sck) begin n_fail++; $display("FAIL sck c=%0d got %b exp %b", c, spi_sck, exp_sck); end
      n_run++; if (spi_cs_n !== exp_cs) begin n_fail++; $display("FAIL cs_n c=%0d got %h exp %h", c, spi_cs_n, exp_cs); end
      chk_mosi = 1'b0;
      exp_mosi = 1'b0;
      if (bad) chk_mosi = 1'b1;
      else if (!m_cpha && c <= 2 * L * H) begin
        chk_mosi = 1'b1;
        exp_mosi = tx_bits[(c - 1) / (2 * H)];
      end else if (m_cpha && c >= 1 + H && c <= 2 * L * H) begin
        chk_mosi = 1'b1;
        exp_mosi = tx_bits[(c - 1 - H) / (2 * H)];
      end
      if (chk_mosi) begin
        n_run++; if (spi_mosi !== exp_mosi) begin n_fail++; $display("FAIL mosi c=%0d got %b exp %b", c, spi_mosi, exp_mosi); end
      end
      if (c == D) begin
        if (!bad) exp_dout = word;
        n_run++; if (data_out !== exp_dout) begin n_fail++; $display("FAIL data_out c=%0d got %h exp %h", c, data_out, exp_dout); end
      end
      // slave presents bit j over the same window the master drives its bit j
      if (!bad && !m_cpha && c <= 2 * L * H) spi_miso = sw_bits[(c - 1) / (2 * H)];
      else if (!bad && m_cpha && c >= 1 + H && c <= 2 * L * H) spi_miso = sw_bits[(c - 1 - H) / (2 * H)];
      else spi_miso = 1'($urandom);
      scramble();
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_busy got %b exp 0", busy); end
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL post_done got %b exp 0", done); end
    n_run++; if (data_out !== exp_dout) begin n_fail++; $display("FAIL post_data_out got %h exp %h", data_out, exp_dout); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpol = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b exp 0", busy); end
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b exp 0", done); end
    n_run++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset err got %b exp 0", err); end
    n_run++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL reset data_out got %h exp 0000", data_out); end
    n_run++; if (spi_sck !== 1'b0) begin n_fail++; $display("FAIL reset sck got %b exp 0", spi_sck); end
    n_run++; if (spi_mosi !== 1'b0) begin n_fail++; $display("FAIL reset mosi got %b exp 0", spi_mosi); end
    n_run++; if (spi_cs_n !== 5'h1f) begin n_fail++; $display("FAIL reset cs_n got %h exp 1f", spi_cs_n); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      cpol = 1'(i);
      @(posedge clk);
      #1;
      n_run++; if (spi_sck !== cpol) begin n_fail++; $display("FAIL idle_sck got %b exp %b", spi_sck, cpol); end
      n_run++; if (spi_cs_n !== 5'h1f || spi_mosi !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL idle_bus cs_n=%h mosi=%b busy=%b exp 1f/0/0", spi_cs_n, spi_mosi, busy);
      end
    end
  endtask

  task automatic test_mode0();
    run_xfer(1'b0, 1'b0, 1'b0, 3'd0, 5'd8, 8'd1, 16'h00A5, 16'h003C, 1'b0, 0);
  endtask

  task automatic test_modes();
    logic [1:0] m;
    for (int i = 1; i < 4; i++) begin
      m = 2'(i);
      run_xfer(m[1], m[0], 1'b0, 3'd0, 5'd8, 8'd1, 16'h00A5, 16'h003C, 1'b0, 0);
    end
  endtask

  task automatic test_lsb();
    run_xfer(1'b0, 1'b0, 1'b1, 3'd2, 5'd12, 8'd1, 16'h0F81, 16'($urandom), 1'b0, 0);
    run_xfer(1'b1, 1'b1, 1'b1, 3'd2, 5'd12, 8'd2, 16'h0F81, 16'($urandom), 1'b0, 0);
  endtask

  task automatic test_len_edges();
    run_xfer(1'b0, 1'b0, 1'b0, 3'd1, 5'd0, 8'd0, 16'($urandom), 16'($urandom), 1'b0, 0);
    run_xfer(1'b1, 1'b1, 1'b0, 3'd4, 5'd20, 8'd0, 16'($urandom), 16'($urandom), 1'b0, 0);
    run_xfer(1'b0, 1'b1, 1'b1, 3'd3, 5'd1, 8'd3, 16'($urandom), 16'($urandom), 1'b0, 0);
  endtask

  task automatic test_bad_cs();
    run_xfer(1'b0, 1'b0, 1'b0, 3'd5, 5'd8, 8'd1, 16'h00A5, 16'h003C, 1'b0, 0);
    run_xfer(1'b1, 1'b0, 1'b1, 3'd7, 5'd4, 8'd2, 16'($urandom), 16'($urandom), 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    run_xfer(1'b0, 1'b0, 1'b0, 3'd0, 5'd8, 8'd1, 16'h00A5, 16'h003C, 1'b0, 10);
    run_xfer(1'b0, 1'b1, 1'b0, 3'd1, 5'd8, 8'd1, 16'h5A5A, 16'h00C3, 1'b0, 0);
  endtask

  task automatic test_start_busy();
    run_xfer(1'b1, 1'b0, 1'b0, 3'd3, 5'd6, 8'd2, 16'($urandom), 16'($urandom), 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      run_xfer(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 4)),
               5'($urandom_range(1, 16)), 8'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_xfer(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 5)),
               5'($urandom_range(0, 18)), 8'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_mode0();
    test_modes();
    test_lsb();
    test_len_edges();
    test_bad_cs();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master_mode.md
# spi_master_mode

Parametrised, mode-configurable SPI master for host-to-peripheral transfers. It supports all four CPOL/CPHA modes, a run-time clock divider, a run-time transfer length of 1..DATA_WIDTH bits, MSB- or LSB-first ordering, and NUM_CS one-hot chip selects. It sits between the host control logic and the external SPI bus.

## Interface
- DATA_WIDTH, default 16: maximum bits per transfer; width of data_in and data_out.
- NUM_CS, default 4: number of chip-select lines.
- DIV_WIDTH, default 8: width of clk_div.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request a transfer; accepted only in IDLE.
- cpol  in  1  SCK idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- lsb_first  in  1  bit order; 0 sends the MSB of the active length first.
- cs_sel  in  $clog2(NUM_CS) (min 1)  target slave index.
- len  in  $clog2(DATA_WIDTH)+1  bits per transfer; 0 or values above DATA_WIDTH are treated as DATA_WIDTH.
- clk_div  in  DIV_WIDTH  SCK half-period is H = clk_div+1 clk cycles; 0 is treated as 1, so H is at least 2.
- data_in  in  DATA_WIDTH  TX word, right-aligned; bits [len-1:0] are used.
- busy  out  1  high from the cycle after start is accepted until the DONE cycle.
- done  out  1  one-cycle pulse at the end of a transfer.
- err  out  1  one-cycle pulse, coincident with done, when cs_sel >= NUM_CS.
- data_out  out  DATA_WIDTH  RX word, right-aligned, with upper bits zero; it holds until the next done.
- spi_sck, spi_mosi  out  1  SPI clock and data out.
- spi_cs_n  out  NUM_CS  active-low chip selects; at most one is low at a time.
- spi_miso  in  1  SPI data in.

## Operation
- FSM states: IDLE -> SETUP -> TRANSFER -> HOLD -> DONE -> IDLE.
- IDLE:
  - spi_sck follows the cpol input, registered.
  - All cs_n lines are high; mosi is 0.
  - When start is high, latch cpol, cpha, lsb_first, cs_sel, the effective len, the effective H and data_in.
- SETUP (H cycles):
  - The selected cs_n goes low and sck = cpol.
  - If cpha=0, the first bit is already on mosi.
- TRANSFER: 2·len SCK edges, spaced H cycles apart. Leading edges are odd-numbered, trailing edges even-numbered.
  - cpha=0: sample miso on each leading edge; shift out the next bit on each trailing edge except the last.
  - cpha=1: shift out a bit on each leading edge; sample miso on each trailing edge.
- HOLD (H cycles): sck = cpol; cs_n remains low.
- DONE (1 cycle):
  - All cs_n lines high; busy=0; done=1.
  - data_out is loaded with the len sampled bits. For lsb_first, the first sampled bit goes to data_out[0].
- Invalid cs_sel:
  - The next cycle goes straight to DONE with err=1.
  - No SCK, cs_n or mosi activity; data_out is unchanged.
- start outside IDLE is ignored, including in the DONE cycle. Back-to-back transfers are possible one cycle after done.

## Timing
- Reset values: busy=0, done=0, err=0, data_out=0, spi_sck=0, spi_mosi=0, spi_cs_n all 1, state IDLE.
- Reset mid-transfer: at the next clk edge, every output takes its reset value and the partial RX is discarded.
- With start accepted at cycle 0:
  - SETUP covers cycles 1..H.
  - SCK edge k (k = 1..2·len) appears on spi_sck at cycle 1+k·H.
  - HOLD ends at cycle (2·len+1)·H.
  - done is high at cycle 1+(2·len+1)·H.
- miso is sampled in the same clk cycle that the sampling SCK edge is registered.
- mosi changes in the same cycle as its shift edge. With cpha=0, the first bit is valid from cycle 1.

## Structure
- spi_pkg holds:
  - the state enum IDLE/SETUP/TRANSFER/HOLD/DONE;
  - a packed mode struct {cpol, cpha, lsb_first};
  - a localparam for the minimum H.
- One sub-module, spi_sck_gen:
  - half-period counter that emits a tick every H cycles while enabled;
  - also provides an edge index and a leading/trailing flag.

## Test plan
- Mode 0, MSB-first, len=8, clk_div=1, data_in=0xA5, slave echoes 0x3C -> mosi bits 1,0,1,0,0,1,0,1; data_out=0x003C; done at cycle 35.
- Modes 1, 2 and 3 with the same stimulus -> SCK idle level equals cpol throughout; sample and shift edges follow the cpha rules; data_out=0x003C in every mode.
- lsb_first=1, len=12, data_in=0x0F81, cs_sel=2 -> only spi_cs_n[2] goes low; mosi sends 1,0,0,0,0,0,0,1,1,1,1,0; RX is right-aligned.
- len=0, clk_div=0 -> runs as 16 bits with H=2; done at cycle 1+33·2=67.
- cs_sel=5 with NUM_CS=4 -> done and err both pulse at cycle 2; no bus activity.
- rst_n low at cycle 10 of a transfer -> all outputs at reset values at cycle 11; a new start after reset completes normally; start while busy is ignored.
